bus_mem_responder: RTL and testbench

- Responder end of the shared command bus that cycle managers drive with read_q/write_q, addr and data.
- Decodes requests whose address falls inside its window and services them from a local word-addressed RAM.
- Answers with a single-cycle read_dn/write_dn pulse and holds is_bus_busy for the duration of the transaction.
- Serves as the program/register memory model for the fetch path: IP-register read, command read, IP write-back.

---
 rtl/bus_mem_responder.sv | 147 ++++++++++++++
 tb/tb_bus_mem_responder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_mem_responder.sv
// Responder on the shared command bus. It claims requests inside its address
// window and services them from a local word-addressed RAM. Each accepted
// request produces one read_dn/write_dn pulse after a fixed number of wait
// states, and is_bus_busy covers the whole transaction.
module bus_mem_responder #(
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       DATA_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int unsigned       DEPTH_LOG2  = 8,
    parameter int unsigned       WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              read_q,
    input  logic              write_q,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              read_dn,
    output logic              write_dn,
    output logic [ADDR_W-1:0] addr_out,
    output logic [DATA_W-1:0] data_out,
    output logic              is_bus_busy,
    output logic              req_err
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    // Window size held one bit wider than the address so a window covering
    // the whole address space still compares correctly.
    localparam logic [ADDR_W:0] WINDOW    = {{ADDR_W{1'b0}}, 1'b1} << DEPTH_LOG2;
    localparam logic [3:0]      WAIT_INIT = 4'(WAIT_CYCLES);

    logic [1:0]            r_state;
    logic [3:0]            r_cnt;
    logic                  r_read_dn;
    logic                  r_write_dn;
    logic [ADDR_W-1:0]     r_addr_out;
    logic [DATA_W-1:0]     r_data_out;
    logic                  r_busy;
    logic                  r_req_err;

    logic [ADDR_W-1:0]     r_addr_lat;
    logic [DATA_W-1:0]     r_data_lat;
    logic [DEPTH_LOG2-1:0] r_idx_lat;
    logic                  r_wr_lat;

    logic [DATA_W-1:0]     r_mem [2**DEPTH_LOG2];

    logic [ADDR_W-1:0]     w_offset;
    logic                  w_hit;
    logic                  w_req;
    logic                  w_accept;

    // Subtraction below BASE_ADDR wraps, so the explicit >= test is what
    // turns low addresses into misses.
    assign w_offset = addr_in - BASE_ADDR;
    assign w_hit    = (addr_in >= BASE_ADDR) && ({1'b0, w_offset} < WINDOW);
    assign w_req    = read_q | write_q;
    assign w_accept = (r_state == S_IDLE) && w_req && w_hit;

    assign read_dn     = r_read_dn;
    assign write_dn    = r_write_dn;
    assign addr_out    = r_addr_out;
    assign data_out    = r_data_out;
    assign is_bus_busy = r_busy;
    assign req_err     = r_req_err;

    // Capture the request on accept; write wins when both request lines are high.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_addr_lat <= addr_in;
            r_data_lat <= data_in;
            r_idx_lat  <= w_offset[DEPTH_LOG2-1:0];
            r_wr_lat   <= write_q;
        end
    end

    // RAM write port: commits only at the DONE edge, so a reset during the
    // wait states drops the write.
    always_ff @(posedge clk) begin
        if ((r_state == S_DONE) && r_wr_lat) begin
            r_mem[r_idx_lat] <= r_data_lat;
        end
    end

    // Transaction sequencer and registered bus outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_read_dn  <= 1'b0;
            r_write_dn <= 1'b0;
            r_addr_out <= '0;
            r_data_out <= '0;
            r_busy     <= 1'b0;
            r_req_err  <= 1'b0;
        end else begin
            r_req_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_busy    <= 1'b1;
                        r_req_err <= read_q & write_q;
                        if (WAIT_CYCLES != 0) begin
                            r_state <= S_WAIT;
                            r_cnt   <= WAIT_INIT;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt <= 4'd1) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_addr_out <= r_addr_lat;
                    if (r_wr_lat) begin
                        r_write_dn <= 1'b1;
                    end else begin
                        r_read_dn  <= 1'b1;
                        r_data_out <= r_mem[r_idx_lat];
                    end
                    r_state <= S_RELEASE;
                end
                default: begin
                    // Outputs drop after one cycle; wait for the request level
                    // to fall so one level yields exactly one service.
                    r_read_dn  <= 1'b0;
                    r_write_dn <= 1'b0;
                    r_addr_out <= '0;
                    r_data_out <= '0;
                    r_busy     <= 1'b0;
                    if (!w_req) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_mem_responder.sv
// Bench for bus_mem_responder: scoreboarded random and directed traffic on a
// WAIT_CYCLES=1 instance, plus latency checks on WAIT_CYCLES=0 and 4 instances.
module tb_bus_mem_responder;

    localparam logic [31:0] BASE  = 32'h100;
    localparam int          DEPTH = 256;
    localparam int          WMAIN = 1;

    logic        clk;
    logic        rst_n;

    logic        read_q, write_q;
    logic [31:0] addr_in, data_in;
    logic        read_dn, write_dn, is_bus_busy, req_err;
    logic [31:0] addr_out, data_out;

    logic        l_read_q, l_write_q;
    logic [31:0] l_addr, l_data;
    logic        w0_rdn, w0_wdn, w0_busy, w0_err;
    logic [31:0] w0_aout, w0_dout;
    logic        w4_rdn, w4_wdn, w4_busy, w4_err;
    logic [31:0] w4_aout, w4_dout;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        bit          err;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] mem_m [DEPTH];
    int          n_checks = 0;
    int          n_err    = 0;
    bit          seen_err = 0;

    bus_mem_responder #(.ADDR_W(32), .DATA_W(32), .BASE_ADDR(BASE), .DEPTH_LOG2(8), .WAIT_CYCLES(WMAIN)) u_dut (
        .clk(clk), .rst_n(rst_n), .read_q(read_q), .write_q(write_q),
        .addr_in(addr_in), .data_in(data_in), .read_dn(read_dn), .write_dn(write_dn),
        .addr_out(addr_out), .data_out(data_out), .is_bus_busy(is_bus_busy), .req_err(req_err)
    );

    bus_mem_responder #(.ADDR_W(32), .DATA_W(32), .BASE_ADDR(BASE), .DEPTH_LOG2(8), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst_n(rst_n), .read_q(l_read_q), .write_q(l_write_q),
        .addr_in(l_addr), .data_in(l_data), .read_dn(w0_rdn), .write_dn(w0_wdn),
        .addr_out(w0_aout), .data_out(w0_dout), .is_bus_busy(w0_busy), .req_err(w0_err)
    );

    bus_mem_responder #(.ADDR_W(32), .DATA_W(32), .BASE_ADDR(BASE), .DEPTH_LOG2(8), .WAIT_CYCLES(4)) u_w4 (
        .clk(clk), .rst_n(rst_n), .read_q(l_read_q), .write_q(l_write_q),
        .addr_in(l_addr), .data_in(l_data), .read_dn(w4_rdn), .write_dn(w4_wdn),
        .addr_out(w4_aout), .data_out(w4_dout), .is_bus_busy(w4_busy), .req_err(w4_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse of the main instance.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            seen_err = 0;
        end else begin
            if (req_err) seen_err = 1;
            if (read_dn || write_dn) begin
                if (sb_q.size() == 0) begin
                    check(1'b0, "unexpected_dn", {30'd0, read_dn, write_dn}, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check((write_dn == e.wr) && (read_dn == !e.wr), "dn_kind", {30'd0, read_dn, write_dn}, {30'd0, !e.wr, e.wr});
                    check(addr_out == e.addr, "addr_out", addr_out, e.addr);
                    check(data_out == e.data, "data_out", data_out, e.data);
                    check(seen_err == e.err, "req_err", {31'd0, seen_err}, {31'd0, e.err});
                    seen_err = 0;
                end
            end else begin
                check((data_out == 32'd0) && (addr_out == 32'd0), "idle_outputs", data_out | addr_out, 32'd0);
            end
        end
    end

    // One bus transaction on the main instance; starts and ends just after a falling edge.
    task automatic txn(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d, input int hold);
        exp_t e;
        bit   hit;
        bit   got;
        int   cyc;
        hit = (a >= BASE) && ((a - BASE) < DEPTH);
        if (hit) begin
            e.wr   = wr;
            e.addr = a;
            e.data = wr ? 32'd0 : mem_m[int'(a - BASE)];
            e.err  = rd && wr;
            sb_q.push_back(e);
            if (wr) mem_m[int'(a - BASE)] = d;
        end
        read_q = rd; write_q = wr; addr_in = a; data_in = d;
        if (!hit) begin
            repeat (20) begin
                @(negedge clk);
                check(!is_bus_busy && !read_dn && !write_dn, "miss_ignored", {29'd0, is_bus_busy, read_dn, write_dn}, 32'd0);
            end
        end else begin
            got = 0;
            cyc = 0;
            while (!got && cyc < 40) begin
                @(negedge clk);
                cyc++;
                check(is_bus_busy, "busy_held", {31'd0, is_bus_busy}, 32'd1);
                if (read_dn || write_dn) got = 1;
            end
            check(got && (cyc == WMAIN + 2), "latency", cyc, WMAIN + 2);
            repeat (hold) @(negedge clk);
        end
        read_q = 1'b0; write_q = 1'b0;
        @(negedge clk);
    endtask

    // Same request to the WAIT_CYCLES=0 and =4 instances, timing both done pulses.
    task automatic lat_txn(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp_rd);
        int c0, c4;
        bit b0, b4;
        c0 = 0; c4 = 0; b0 = 1; b4 = 1;
        l_read_q = rd; l_write_q = wr; l_addr = a; l_data = d;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c0 == 0 && !w0_busy) b0 = 0;
            if (c4 == 0 && !w4_busy) b4 = 0;
            if (c0 != 0 && (w0_rdn || w0_wdn)) b0 = 0;
            if (c4 != 0 && (w4_rdn || w4_wdn)) b4 = 0;
            if (c0 == 0 && (w0_rdn || w0_wdn)) begin
                c0 = c;
                check(rd ? (w0_rdn && w0_dout == exp_rd) : w0_wdn, "w0_result", w0_dout, rd ? exp_rd : 32'd0);
                check(w0_aout == a, "w0_addr_out", w0_aout, a);
            end
            if (c4 == 0 && (w4_rdn || w4_wdn)) begin
                c4 = c;
                check(rd ? (w4_rdn && w4_dout == exp_rd) : w4_wdn, "w4_result", w4_dout, rd ? exp_rd : 32'd0);
                check(w4_aout == a, "w4_addr_out", w4_aout, a);
            end
        end
        check(c0 == 2, "w0_latency", c0, 2);
        check(c4 == 6, "w4_latency", c4, 6);
        check(b0, "w0_busy_single", {31'd0, b0}, 32'd1);
        check(b4, "w4_busy_single", {31'd0, b4}, 32'd1);
        l_read_q = 1'b0; l_write_q = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        int          r;
        bit          rd, wr;
        rst_n = 1'b0;
        read_q = 0; write_q = 0; addr_in = 0; data_in = 0;
        l_read_q = 0; l_write_q = 0; l_addr = 0; l_data = 0;
        repeat (3) @(negedge clk);
        check(!read_dn && !write_dn && !is_bus_busy && !req_err && addr_out == 0 && data_out == 0,
              "reset_state", addr_out | data_out, 32'd0);
        check(!w0_busy && !w4_busy && !w0_err && !w4_err, "reset_state_lat", {30'd0, w0_busy, w4_busy}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Known contents for the whole window; 0x120 is left at zero.
        for (int i = 0; i < DEPTH; i++) begin
            d = (i == 32'h20) ? 32'd0 : $urandom;
            txn(1'b0, 1'b1, BASE + i, d, 0);
        end

        txn(1'b0, 1'b1, 32'h105, 32'hDEADBEEF, 0);
        txn(1'b1, 1'b0, 32'h105, 32'h0, 0);

        txn(1'b1, 1'b0, 32'hFF,  32'h0, 0);
        txn(1'b1, 1'b0, 32'h200, 32'h0, 0);
        txn(1'b1, 1'b0, 32'h1FF, 32'h0, 0);

        txn(1'b1, 1'b0, 32'h105, 32'h0, 10);
        txn(1'b1, 1'b0, 32'h105, 32'h0, 0);

        txn(1'b1, 1'b1, 32'h110, 32'h5A, 0);
        txn(1'b1, 1'b0, 32'h110, 32'h0, 0);

        // Reset during the wait state of a write: nothing may be committed.
        write_q = 1'b1; addr_in = 32'h120; data_in = 32'h1234;
        @(negedge clk);
        check(is_bus_busy, "reset_txn_accepted", {31'd0, is_bus_busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check(!read_dn && !write_dn && !is_bus_busy && !req_err && addr_out == 0 && data_out == 0,
              "async_reset_outputs", {29'd0, is_bus_busy, read_dn, write_dn}, 32'd0);
        write_q = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        txn(1'b1, 1'b0, 32'h120, 32'h0, 0);

        lat_txn(1'b0, 1'b1, 32'h140, 32'hCAFEF00D, 32'h0);
        lat_txn(1'b1, 1'b0, 32'h140, 32'h0, 32'hCAFEF00D);

        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 19);
            d = $urandom;
            if (r == 0) begin
                a = $urandom_range(0, 32'hFF);
                txn(1'b1, 1'b0, a, d, 0);
            end else if (r == 1) begin
                a = 32'h200 + $urandom_range(0, 32'hFFFF);
                txn(1'b0, 1'b1, a, d, 0);
            end else begin
                a  = BASE + $urandom_range(0, DEPTH - 1);
                rd = ($urandom_range(0, 1) == 1);
                wr = !rd || ($urandom_range(0, 7) == 0);
                txn(rd, wr, a, d, $urandom_range(0, 3));
            end
        end

        repeat (3) @(negedge clk);
        check(sb_q.size() == 0, "scoreboard_drained", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
